riscv_instr_feeder: RTL and testbench

Parametrised instruction-feed block that sits between a stimulus/loader source and the RISC-V core's instruction port. It queues instruction words, issues the next word each time the core's program counter advances, and fills underruns with NOPs or holds the last word, per mode. It also latches and counts traps and flushes on them. It supersedes the bare pc/instr/trap signal bundle with a buffered, trap-aware, width-configurable feeder.

---
 rtl/riscv_feed_pkg.sv | 13 +
 rtl/riscv_feed_fifo.sv | 56 +++++
 rtl/riscv_instr_feeder.sv | 135 +++++++++++++
 tb/tb_riscv_instr_feeder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_feed_pkg.sv
// Shared types and constants for the RISC-V instruction feeder.
package riscv_feed_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      TRAPPED = 2'd2
   } feed_state_t;

   // addi x0,x0,0
   localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_feed_fifo.sv
// Synchronous FIFO for instruction words; the head is readable without a pop
// so the feeder can capture it on the same edge that removes it.
module riscv_feed_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB separates full from empty when the indices match.
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign level    = wr_ptr_reg - rd_ptr_reg;
   assign data_out = mem[rd_ptr_reg[AW-1:0]];

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/riscv_instr_feeder.sv
// Buffered, trap-aware instruction feeder: issues one queued word per program
// counter advance, fills underruns, and flushes on core traps.
module riscv_instr_feeder
   import riscv_feed_pkg::*;
#(
   parameter int                   PC_W    = 32,
   parameter int                   INSTR_W = 32,
   parameter int                   DEPTH   = 8,
   parameter logic [INSTR_W-1:0]   NOP     = INSTR_W'(DEFAULT_NOP),
   parameter int                   CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INSTR_W-1:0]       in_instr,
   input  logic [PC_W-1:0]          pc,
   input  logic                     trap,
   input  logic                     fill_nop,
   input  logic                     trap_clear,
   output logic [INSTR_W-1:0]       instr,
   output logic                     instr_valid,
   output logic                     trapped,
   output logic [PC_W-1:0]          trap_pc,
   output logic [CNT_W-1:0]         trap_count,
   output logic [CNT_W-1:0]         issued_count,
   output logic [CNT_W-1:0]         underrun_count,
   output logic [$clog2(DEPTH):0]   level
);

   feed_state_t        state_reg;
   logic [PC_W-1:0]    pc_last_reg;
   logic [INSTR_W-1:0] instr_reg;
   logic               instr_valid_reg;
   logic [PC_W-1:0]    trap_pc_reg;
   logic [CNT_W-1:0]   trap_count_reg;
   logic [CNT_W-1:0]   issued_count_reg;
   logic [CNT_W-1:0]   underrun_count_reg;

   logic               fifo_full;
   logic               fifo_empty;
   logic [INSTR_W-1:0] fifo_head;
   logic               advance;
   logic               trap_take;
   logic               push;
   logic               pop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign advance   = (state_reg == RUN) && (pc != pc_last_reg);
   assign trap_take = (state_reg != TRAPPED) && trap;
   assign in_ready  = reset && (state_reg != TRAPPED) && !fifo_full && !trap;
   assign push      = in_valid && in_ready;
   assign pop       = !trap_take && !fifo_empty &&
                      ((state_reg == IDLE) || advance);

   riscv_feed_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .flush    (trap_take),
      .data_in  (in_instr),
      .data_out (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (level)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg          <= IDLE;
         pc_last_reg        <= '0;
         instr_reg          <= NOP;
         instr_valid_reg    <= 1'b0;
         trap_pc_reg        <= '0;
         trap_count_reg     <= '0;
         issued_count_reg   <= '0;
         underrun_count_reg <= '0;
      end else begin
         // Tracked in every state so entering RUN never sees a stale advance.
         pc_last_reg <= pc;
         case (state_reg)
            IDLE, RUN: begin
               if (trap) begin
                  state_reg       <= TRAPPED;
                  trap_pc_reg     <= pc;
                  trap_count_reg  <= sat_inc(trap_count_reg);
                  instr_reg       <= NOP;
                  instr_valid_reg <= 1'b0;
               end else if (state_reg == IDLE) begin
                  if (!fifo_empty) begin
                     state_reg        <= RUN;
                     instr_reg        <= fifo_head;
                     instr_valid_reg  <= 1'b1;
                     issued_count_reg <= sat_inc(issued_count_reg);
                  end
               end else if (advance) begin
                  if (!fifo_empty) begin
                     instr_reg        <= fifo_head;
                     instr_valid_reg  <= 1'b1;
                     issued_count_reg <= sat_inc(issued_count_reg);
                  end else begin
                     underrun_count_reg <= sat_inc(underrun_count_reg);
                     if (fill_nop) begin
                        instr_reg       <= NOP;
                        instr_valid_reg <= 1'b1;
                     end else begin
                        instr_valid_reg <= 1'b0;
                     end
                  end
               end
            end
            TRAPPED: begin
               if (trap_clear && !trap) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign instr          = instr_reg;
   assign instr_valid    = instr_valid_reg;
   assign trapped        = (state_reg == TRAPPED);
   assign trap_pc        = trap_pc_reg;
   assign trap_count     = trap_count_reg;
   assign issued_count   = issued_count_reg;
   assign underrun_count = underrun_count_reg;

endmodule

// File: tb/tb_riscv_instr_feeder.sv
// Bench for riscv_instr_feeder: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_riscv_instr_feeder;

   localparam int          DEPTH = 8;
   localparam logic [31:0] NOPW  = 32'h0000_0013;
   localparam int          CMAX  = 65535;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] pc = '0;
   logic        trap = 1'b0;
   logic        fill_nop = 1'b0;
   logic        trap_clear = 1'b0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        trapped;
   logic [31:0] trap_pc;
   logic [15:0] trap_count;
   logic [15:0] issued_count;
   logic [15:0] underrun_count;
   logic [3:0]  level;

   riscv_instr_feeder dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_instr       (in_instr),
      .pc             (pc),
      .trap           (trap),
      .fill_nop       (fill_nop),
      .trap_clear     (trap_clear),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .trapped        (trapped),
      .trap_pc        (trap_pc),
      .trap_count     (trap_count),
      .issued_count   (issued_count),
      .underrun_count (underrun_count),
      .level          (level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: a plain queue plus running/trapped flags.
   logic [31:0] mq[$];
   bit          m_running;
   bit          m_trapped;
   logic [31:0] m_instr;
   bit          m_valid;
   logic [31:0] m_tpc;
   logic [31:0] m_pc_last;
   int          m_tcnt;
   int          m_iss;
   int          m_und;

   typedef struct {
      bit          v;
      logic [31:0] d;
      logic [31:0] p;
      bit          fn;
      logic [31:0] e_instr;
      bit          e_valid;
      int          e_level;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x < CMAX) ? x + 1 : x;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_running = 0;
      m_trapped = 0;
      m_instr   = NOPW;
      m_valid   = 0;
      m_tpc     = '0;
      m_pc_last = '0;
      m_tcnt    = 0;
      m_iss     = 0;
      m_und     = 0;
   endtask

   task automatic check_all();
      chk("instr", instr, m_instr);
      chk("instr_valid", instr_valid, m_valid);
      chk("trapped", trapped, m_trapped);
      chk("trap_pc", trap_pc, m_tpc);
      chk("trap_count", trap_count, m_tcnt);
      chk("issued_count", issued_count, m_iss);
      chk("underrun_count", underrun_count, m_und);
      chk("level", level, mq.size());
   endtask

   // Called away from clock edges; checks reset values before any edge occurs.
   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0; trap = 1'b0; trap_clear = 1'b0; pc = '0;
      #1;
      model_reset();
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_valid", instr_valid, 0);
      chk("rst_trapped", trapped, 0);
      chk("rst_trap_pc", trap_pc, 0);
      chk("rst_trap_count", trap_count, 0);
      chk("rst_issued", issued_count, 0);
      chk("rst_underrun", underrun_count, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic cycle(input bit v, input logic [31:0] d, input logic [31:0] p,
                        input bit t, input bit fn, input bit tc);
      bit exp_rdy;
      bit do_push;
      in_valid = v; in_instr = d; pc = p; trap = t; fill_nop = fn; trap_clear = tc;
      #1;
      exp_rdy = !m_trapped && (mq.size() < DEPTH) && !t;
      chk("in_ready", in_ready, exp_rdy);
      do_push = v && exp_rdy;
      if (!m_trapped && t) begin
         m_trapped = 1; m_running = 0;
         m_tpc = p; m_tcnt = sat(m_tcnt);
         mq.delete();
         m_instr = NOPW; m_valid = 0;
      end else if (m_trapped) begin
         if (tc && !t) m_trapped = 0;
      end else if (!m_running) begin
         if (mq.size() > 0) begin
            m_instr = mq.pop_front(); m_valid = 1; m_iss = sat(m_iss); m_running = 1;
         end
      end else if (p != m_pc_last) begin
         if (mq.size() > 0) begin
            m_instr = mq.pop_front(); m_valid = 1; m_iss = sat(m_iss);
         end else begin
            m_und = sat(m_und);
            if (fn) begin m_instr = NOPW; m_valid = 1; end
            else m_valid = 0;
         end
      end
      if (do_push) mq.push_back(d);
      m_pc_last = p;
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{1'b1, 32'h00A0_0093, 32'h0, 1'b1, NOPW,          1'b0, 1};
      tbl[1] = '{1'b1, 32'h00B0_0113, 32'h0, 1'b1, 32'h00A0_0093, 1'b1, 1};
      tbl[2] = '{1'b0, 32'h0,         32'h4, 1'b1, 32'h00B0_0113, 1'b1, 0};
      tbl[3] = '{1'b0, 32'h0,         32'h8, 1'b0, 32'h00B0_0113, 1'b0, 0};
      tbl[4] = '{1'b0, 32'h0,         32'h8, 1'b1, 32'h00B0_0113, 1'b0, 0};
      tbl[5] = '{1'b0, 32'h0,         32'hC, 1'b1, NOPW,          1'b1, 0};
      tbl[6] = '{1'b1, 32'h0000_0111, 32'hC, 1'b1, NOPW,          1'b1, 1};
      tbl[7] = '{1'b0, 32'h0,         32'h10, 1'b1, 32'h0000_0111, 1'b1, 0};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].p, 1'b0, tbl[i].fn, 1'b0);
         chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
         chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
         chk($sformatf("tbl%0d_level", i), level, tbl[i].e_level);
      end
      chk("tbl_issued", issued_count, 3);
      chk("tbl_underrun", underrun_count, 2);

      // Fill to full: first word is popped on entering RUN, eight remain.
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1'b1, 32'h1000 + i, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("full_level", level, 8);
      chk("full_ready", in_ready, 0);
      cycle(1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("full_push_ignored", level, 8);
      cycle(1'b0, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0);
      chk("full_adv_level", level, 7);
      chk("full_adv_instr", instr, 32'h1001);
      chk("full_adv_ready", in_ready, 1);

      // Trap with five words queued, then release.
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1'b1, 32'h3000 + i, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("pretrap_level", level, 5);
      cycle(1'b0, 32'h0, 32'h80, 1'b1, 1'b1, 1'b0);
      trap = 1'b0;
      #1;
      chk("trap_trapped", trapped, 1);
      chk("trap_pc_val", trap_pc, 32'h80);
      chk("trap_cnt", trap_count, 1);
      chk("trap_level", level, 0);
      chk("trap_ready", in_ready, 0);
      @(negedge clk);
      cycle(1'b0, 32'h0, 32'h80, 1'b1, 1'b1, 1'b1);
      chk("trap_hold", trapped, 1);
      chk("trap_cnt_hold", trap_count, 1);
      cycle(1'b0, 32'h0, 32'h80, 1'b0, 1'b1, 1'b1);
      chk("trap_release", trapped, 0);

      // Simultaneous push and advance at level 3.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h2000 + i, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("sim_pre_level", level, 3);
      cycle(1'b1, 32'h2004, 32'h4, 1'b0, 1'b1, 1'b0);
      chk("sim_level", level, 3);
      chk("sim_instr", instr, 32'h2001);

      // Mid-stream reset at level 4; do_reset checks values before any edge.
      for (int i = 0; i < 1; i++) cycle(1'b1, 32'h2005, 32'h4, 1'b0, 1'b1, 1'b0);
      chk("mid_pre_level", level, 4);
      do_reset();

      // Randomized run against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(299) == 0) begin
            do_reset();
         end else begin
            logic [31:0] np;
            np = ($urandom_range(1) == 1) ? pc + 32'd4 : pc;
            cycle(1'($urandom_range(1)), $urandom, np,
                  $urandom_range(39) == 0, 1'($urandom_range(1)),
                  $urandom_range(3) == 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
